// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column strobe, row debounce, key encode, show-ahead press FIFO, press interrupt.
// Push lands (DEBOUNCE-1)*SCAN_DIV cycles after first qualifying sample; full FIFO drops presses and flags overflow.
module keypad_scan_fifo #(
    parameter int ROWS        = 4,
    parameter int COLS        = 3,
    parameter int SCAN_DIV    = 50000,
    parameter int DEBOUNCE    = 4,
    parameter int DEPTH       = 4,
    parameter int INTR_CYCLES = 8,
    parameter int PHONE_MAP   = 1,
    localparam int CODE_W     = ($clog2(ROWS*COLS) > 4) ? $clog2(ROWS*COLS) : 4,
    localparam int CNT_W      = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic [CODE_W-1:0] key_data,
    output logic              key_valid,
    input  logic              key_rd,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              intr
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DBC_W = $clog2(DEBOUNCE+1);
    localparam int AW    = $clog2(DEPTH);
    localparam int IC_W  = $clog2(INTR_CYCLES+1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_cnt;
    logic [COL_W-1:0]   col, col_n, col_adv;
    logic [ROW_W-1:0]   r, r_n, row_idx;
    logic [DBC_W-1:0]   dbc, dbc_n;
    logic               sample, row_match, row_onehot;
    logic               push, accept, pop;
    logic [CODE_W-1:0]  push_code;
    logic [CODE_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [IC_W-1:0]    ic;

    function automatic logic [CODE_W-1:0] encode(input logic [ROW_W-1:0] rr,
                                                 input logic [COL_W-1:0] cc);
        int raw;
        raw = int'(rr) * COLS + int'(cc);
        if (PHONE_MAP != 0) begin
            // bottom row of a phone pad is *, 0, #
            if (int'(rr) == 3)
                raw = (int'(cc) == 0) ? 10 : ((int'(cc) == 1) ? 0 : 11);
            else
                raw = raw + 1;
        end
        return CODE_W'(raw);
    endfunction

    assign sample     = (div_cnt == DIV_W'(SCAN_DIV-1));
    assign col_out    = COLS'(1) << col;
    assign col_adv    = (col == COL_W'(COLS-1)) ? '0 : col + COL_W'(1);
    assign row_onehot = $onehot(row_in);
    assign row_match  = (row_in == (ROWS'(1) << r));

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < ROWS; i++)
            if (row_in[i]) row_idx = ROW_W'(i);
    end

    always_ff @(posedge clk) begin
        if (rst)         div_cnt <= '0;
        else if (sample) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SCAN;
            col   <= '0;
            r     <= '0;
            dbc   <= '0;
        end else begin
            state <= state_n;
            col   <= col_n;
            r     <= r_n;
            dbc   <= dbc_n;
        end
    end

    // col stays frozen outside SCAN, so it doubles as the captured column
    always_comb begin
        state_n   = state;
        col_n     = col;
        r_n       = r;
        dbc_n     = dbc;
        push      = 1'b0;
        push_code = '0;
        if (sample) begin
            case (state)
                S_SCAN: begin
                    if (row_onehot) begin
                        r_n   = row_idx;
                        dbc_n = DBC_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_n   = S_HELD;
                            push      = 1'b1;
                            push_code = encode(row_idx, col);
                        end else begin
                            state_n = S_DEBOUNCE;
                        end
                    end else begin
                        col_n = col_adv;
                    end
                end
                S_DEBOUNCE: begin
                    if (row_match) begin
                        dbc_n = dbc + DBC_W'(1);
                        if (dbc + DBC_W'(1) == DBC_W'(DEBOUNCE)) begin
                            state_n   = S_HELD;
                            push      = 1'b1;
                            push_code = encode(r, col);
                        end
                    end else begin
                        state_n = S_SCAN;
                        col_n   = col_adv;
                    end
                end
                S_HELD: begin
                    if (row_in == '0) begin
                        dbc_n = DBC_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_n = S_SCAN;
                            col_n   = col_adv;
                        end else begin
                            state_n = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (row_in == '0) begin
                        dbc_n = dbc + DBC_W'(1);
                        if (dbc + DBC_W'(1) == DBC_W'(DEBOUNCE)) begin
                            state_n = S_SCAN;
                            col_n   = col_adv;
                        end
                    end else begin
                        state_n = S_HELD;
                    end
                end
                default: state_n = S_SCAN;
            endcase
        end
    end

    // a pop in the same cycle frees the slot a full FIFO needs
    assign pop    = key_rd && (count != '0);
    assign accept = push && ((count != CNT_W'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && !accept) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_code;
    end

    assign key_valid = (count != '0);
    assign key_data  = key_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst)           ic <= '0;
        else if (accept)   ic <= IC_W'(INTR_CYCLES);
        else if (ic != '0) ic <= ic - IC_W'(1);
    end

    assign intr = (ic != '0);

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: 4x3 phone pad, SCAN_DIV=4, DEBOUNCE=3, DEPTH=4, INTR_CYCLES=2.
module tb_keypad_scan_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] kp_row = 4'b0000;
    logic [2:0] kp_col = 3'b000;
    logic [2:0] col_out;
    logic [3:0] key_data;
    logic       key_valid;
    logic       key_rd = 1'b0;
    logic [2:0] count;
    logic       overflow;
    logic       intr;

    int   checks = 0;
    int   errors = 0;
    int   intr_rises = 0;
    int   base;
    logic intr_q = 1'b0;

    keypad_scan_fifo #(
        .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE(3), .DEPTH(4),
        .INTR_CYCLES(2), .PHONE_MAP(1)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_data(key_data), .key_valid(key_valid), .key_rd(key_rd),
        .count(count), .overflow(overflow), .intr(intr)
    );

    always #5 clk = ~clk;

    // keypad: the pressed row returns high only while its column is strobed
    assign row_in = ((col_out & kp_col) != 3'b000) ? kp_row : 4'b0000;

    always @(negedge clk) begin
        if (intr && !intr_q) intr_rises++;
        intr_q = intr;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // returns on the first negedge after col_out switches to mask (dwell counter at 0)
    task automatic wait_col(input logic [2:0] mask);
        logic [2:0] prev;
        bit hit;
        prev = col_out;
        hit  = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (col_out == mask && prev != mask) hit = 1'b1;
            prev = col_out;
        end
        check("wait_col", 32'(hit), 32'd1);
    endtask

    // press lands on the third sample; returns one cycle after the push edge
    task automatic press(input logic [3:0] row, input logic [2:0] colm);
        wait_col(colm);
        kp_row = row;
        kp_col = colm;
        tick(12);
    endtask

    task automatic release_key();
        kp_row = 4'b0000;
        tick(24);
    endtask

    task automatic pop();
        key_rd = 1'b1;
        tick(1);
        key_rd = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},   32'(col_out),   32'h1);
        check({tag, "_valid"}, 32'(key_valid), 32'h0);
        check({tag, "_data"},  32'(key_data),  32'h0);
        check({tag, "_count"}, 32'(count),     32'h0);
        check({tag, "_ovf"},   32'(overflow),  32'h0);
        check({tag, "_intr"},  32'(intr),      32'h0);
    endtask

    logic [3:0] ov_rows  [5] = '{4'b0001, 4'b0001, 4'b0100, 4'b1000, 4'b0010};
    logic [2:0] ov_cols  [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001};
    logic [3:0] ov_codes [5] = '{4'd1, 4'd2, 4'd9, 4'd11, 4'd4};
    logic [3:0] pp_codes [4] = '{4'd2, 4'd9, 4'd11, 4'd4};

    initial begin
        // reset and idle scan
        tick(2);
        rst = 1'b0;
        check_reset_outputs("reset");
        for (int i = 0; i < 16; i++) begin
            check("scan_col", 32'(col_out), 32'(3'b001 << ((i / 4) % 3)));
            tick(1);
        end
        check("scan_valid", 32'(key_valid), 32'h0);
        check("scan_intr",  32'(intr),      32'h0);

        // single press row1/col2 -> '6', exact latency and pulse width
        wait_col(3'b100);
        kp_row = 4'b0010;
        kp_col = 3'b100;
        tick(11);
        check("sp_early_valid", 32'(key_valid), 32'h0);
        tick(1);
        check("sp_valid", 32'(key_valid), 32'h1);
        check("sp_data",  32'(key_data),  32'h6);
        check("sp_count", 32'(count),     32'h1);
        check("sp_intr0", 32'(intr),      32'h1);
        tick(1);
        check("sp_intr1", 32'(intr),      32'h1);
        tick(1);
        check("sp_intr2", 32'(intr),      32'h0);
        tick(100);
        check("sp_hold_count", 32'(count), 32'h1);
        check("sp_hold_intr",  32'(intr),  32'h0);
        release_key();
        pop();
        check("sp_pop_valid", 32'(key_valid), 32'h0);
        check("sp_pop_data",  32'(key_data),  32'h0);

        // bounce on row3/col1: two samples, a gap, then stable -> single '0'
        wait_col(3'b010);
        kp_row = 4'b1000;
        kp_col = 3'b010;
        tick(8);
        check("bn_partial_valid", 32'(key_valid), 32'h0);
        kp_row = 4'b0000;
        tick(4);
        check("bn_abort_col",   32'(col_out),   32'h4);
        check("bn_abort_valid", 32'(key_valid), 32'h0);
        kp_row = 4'b1000;
        press(4'b1000, 3'b010);
        check("bn_valid", 32'(key_valid), 32'h1);
        check("bn_data",  32'(key_data),  32'h0);
        tick(40);
        check("bn_count", 32'(count), 32'h1);
        release_key();
        pop();
        check("bn_pop_count", 32'(count), 32'h0);

        // star key row3/col0 -> 10
        press(4'b1000, 3'b001);
        check("star_data", 32'(key_data), 32'hA);
        release_key();
        pop();

        // two rows on col0: ignored, scan keeps moving
        kp_row = 4'b0101;
        kp_col = 3'b001;
        wait_col(3'b001);
        tick(4);
        check("mk_col1", 32'(col_out), 32'h2);
        tick(4);
        check("mk_col2", 32'(col_out), 32'h4);
        tick(4);
        check("mk_col0", 32'(col_out), 32'h1);
        tick(24);
        check("mk_valid", 32'(key_valid), 32'h0);
        kp_row = 4'b0000;

        // overflow: five presses into a four-entry FIFO
        base = intr_rises;
        for (int i = 0; i < 5; i++) begin
            press(ov_rows[i], ov_cols[i]);
            if (i < 4) begin
                check("ov_count", 32'(count),    32'(i + 1));
                check("ov_intr",  32'(intr),     32'h1);
                check("ov_flag0", 32'(overflow), 32'h0);
            end else begin
                check("ov_full_count", 32'(count),    32'h4);
                check("ov_flag",       32'(overflow), 32'h1);
                check("ov_no_intr",    32'(intr),     32'h0);
            end
            release_key();
        end
        check("ov_pulses", 32'(intr_rises - base), 32'h4);
        for (int i = 0; i < 4; i++) begin
            check("ov_drain_data", 32'(key_data), 32'(ov_codes[i]));
            pop();
            check("ov_drain_count", 32'(count), 32'(3 - i));
        end
        check("ov_empty_valid", 32'(key_valid), 32'h0);
        check("ov_empty_data",  32'(key_data),  32'h0);
        check("ov_sticky",      32'(overflow),  32'h1);

        // full FIFO with a pop on the push cycle
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("pp_reset_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            press(ov_rows[i], ov_cols[i]);
            release_key();
        end
        check("pp_full", 32'(count), 32'h4);
        wait_col(3'b001);
        kp_row = 4'b0010;
        kp_col = 3'b001;
        tick(11);
        key_rd = 1'b1;
        tick(1);
        key_rd = 1'b0;
        check("pp_count", 32'(count),    32'h4);
        check("pp_ovf",   32'(overflow), 32'h0);
        check("pp_intr",  32'(intr),     32'h1);
        release_key();
        for (int i = 0; i < 4; i++) begin
            check("pp_drain_data", 32'(key_data), 32'(pp_codes[i]));
            pop();
        end
        check("pp_empty", 32'(key_valid), 32'h0);

        // reset in the middle of debounce discards the press
        press(4'b0001, 3'b001);
        release_key();
        wait_col(3'b010);
        kp_row = 4'b0001;
        kp_col = 3'b010;
        tick(6);
        rst = 1'b1;
        tick(2);
        rst    = 1'b0;
        kp_row = 4'b0000;
        check_reset_outputs("rst_mid");
        tick(40);
        check("rst_mid_novalid", 32'(key_valid), 32'h0);
        check("rst_mid_nointr",  32'(intr),      32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
